// File: rtl/desc_mem_dp_arb.sv
// rtl/desc_mem_dp_arb.sv - dual Avalon-MM slave descriptor RAM behind a round-robin arbiter
// Optional DESC_MEM_PARITY_EN: per-lane even parity storage, checked on read return (parity_err).
module desc_mem_dp_arb #(
  parameter int    DATA_W       = 32,
  parameter int    ADDR_W       = 13,
  parameter int    DEPTH        = 4100,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = "desc_mem.hex"
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clken,
  input  logic                reset_req,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic                s1_waitrequest,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  input  logic                s2_chipselect,
  input  logic                s2_read,
  input  logic                s2_write,
  input  logic [ADDR_W-1:0]   s2_address,
  input  logic [DATA_W/8-1:0] s2_byteenable,
  input  logic [DATA_W-1:0]   s2_writedata,
  output logic                s2_waitrequest,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid,
  output logic                oob_err
`ifdef DESC_MEM_PARITY_EN
  , output logic              parity_err
`endif
);

  localparam int NB = DATA_W / 8;
`ifdef DESC_MEM_PARITY_EN
  localparam int MEM_W = DATA_W + NB;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam int L = READ_LATENCY - 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [MEM_W-1:0] mem [DEPTH];

  logic              req1, req2, stall, prio, gnt1, gnt2, gnt, sel, is_wr, in_range;
  logic [ADDR_W-1:0] addr;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wdata;

  assign req1  = s1_chipselect & (s1_read | s1_write);
  assign req2  = s2_chipselect & (s2_read | s2_write);
  // Reset is folded into the stall so no grant can ever be issued while it is asserted.
  assign stall = ~clken | reset_req | reset;
  assign gnt1  = ~stall & req1 & (~req2 | ~prio);
  assign gnt2  = ~stall & req2 & (~req1 | prio);
  assign gnt   = gnt1 | gnt2;

  assign s1_waitrequest = req1 & ~gnt1;
  assign s2_waitrequest = req2 & ~gnt2;

  always_comb begin
    sel   = gnt2;
    addr  = s1_address;
    be    = s1_byteenable;
    wdata = s1_writedata;
    is_wr = s1_write;
    if (gnt2) begin
      addr  = s2_address;
      be    = s2_byteenable;
      wdata = s2_writedata;
      is_wr = s2_write;
    end
  end

  assign in_range = {1'b0, addr} < DEPTH_L;
  assign oob_err  = gnt & ~in_range;

  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= 1'b0;
    end else if (~stall && req1 && req2) begin
      prio <= ~prio;
    end
  end

  // RAM contents survive reset; only the enabled lanes (and their parity bits) change.
  always_ff @(posedge clk) begin
    if (gnt && is_wr && in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
`ifdef DESC_MEM_PARITY_EN
          mem[addr][DATA_W+i] <= ^wdata[i*8 +: 8];
`endif
        end
      end
    end
  end

  logic [READ_LATENCY-1:0] pv, ptag;
  logic [MEM_W-1:0]        pdata [READ_LATENCY];
`ifdef DESC_MEM_PARITY_EN
  logic [READ_LATENCY-1:0] poob;
`endif

  // Tag/data pipeline advances only on unstalled cycles; stage 0 is the RAM read register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pv   <= '0;
      ptag <= '0;
      for (int k = 0; k < READ_LATENCY; k++) pdata[k] <= '0;
`ifdef DESC_MEM_PARITY_EN
      poob <= '0;
`endif
    end else if (~stall) begin
      pv[0]    <= gnt & ~is_wr;
      ptag[0]  <= sel;
      pdata[0] <= in_range ? mem[addr] : '0;
`ifdef DESC_MEM_PARITY_EN
      poob[0]  <= ~in_range;
`endif
      for (int k = 1; k < READ_LATENCY; k++) begin
        pv[k]    <= pv[k-1];
        ptag[k]  <= ptag[k-1];
        pdata[k] <= pdata[k-1];
`ifdef DESC_MEM_PARITY_EN
        poob[k]  <= poob[k-1];
`endif
      end
    end
  end

  logic              ret_v;
  logic [DATA_W-1:0] ret_data, hold1, hold2;

  assign ret_v            = pv[L] & ~stall;
  assign ret_data         = pdata[L][DATA_W-1:0];
  assign s1_readdatavalid = ret_v & ~ptag[L];
  assign s2_readdatavalid = ret_v & ptag[L];

  always_ff @(posedge clk) begin
    if (reset) begin
      hold1 <= '0;
      hold2 <= '0;
    end else begin
      if (s1_readdatavalid) hold1 <= ret_data;
      if (s2_readdatavalid) hold2 <= ret_data;
    end
  end

  assign s1_readdata = reset ? '0 : (s1_readdatavalid ? ret_data : hold1);
  assign s2_readdata = reset ? '0 : (s2_readdatavalid ? ret_data : hold2);

`ifdef DESC_MEM_PARITY_EN
  logic [NB-1:0] par_calc;
  always_comb begin
    par_calc = '0;
    for (int i = 0; i < NB; i++) par_calc[i] = ^pdata[L][i*8 +: 8];
  end
  assign parity_err = ret_v & ~poob[L] & (par_calc != pdata[L][DATA_W +: NB]);
`endif

endmodule

// File: tb/tb_desc_mem_dp_arb.sv
// tb/tb_desc_mem_dp_arb.sv - scoreboard bench for desc_mem_dp_arb with a behavioural memory/arbiter model
module tb_desc_mem_dp_arb;
  localparam int DW = 32, AW = 13, DEPTH = 4100, RL = 1;

  logic clk = 1'b0, reset, clken, reset_req;
  logic s1_chipselect, s1_read, s1_write, s1_waitrequest, s1_readdatavalid;
  logic s2_chipselect, s2_read, s2_write, s2_waitrequest, s2_readdatavalid;
  logic [AW-1:0] s1_address, s2_address;
  logic [3:0]    s1_byteenable, s2_byteenable;
  logic [DW-1:0] s1_writedata, s2_writedata, s1_readdata, s2_readdata;
  logic          oob_err;
`ifdef DESC_MEM_PARITY_EN
  logic          parity_err;
`endif

  always #5 clk = ~clk;

  desc_mem_dp_arb #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LATENCY(RL), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write), .s1_address(s1_address),
    .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata), .s1_waitrequest(s1_waitrequest),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
    .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write), .s2_address(s2_address),
    .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata), .s2_waitrequest(s2_waitrequest),
    .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid),
    .oob_err(oob_err)
`ifdef DESC_MEM_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  typedef struct {
    bit rd, wr; logic [AW-1:0] addr; logic [3:0] be; logic [31:0] data;
    bit use_c; logic [31:0] exp_c; bit flip; int gap;
  } cmd_t;
  typedef struct { logic [31:0] data; longint due; bit perr; } exp_t;

  cmd_t q1[$], q2[$];
  cmd_t cur [2];
  bit   cv [2], cd [2];
  int   gapc [2];
  int   gcnt [2];
  exp_t sb1[$], sb2[$];
  logic [31:0] mref [int];
  logic [31:0] hold [2];
  bit     prio_m;
  longint act;
  bit     exp_pe;
  int     errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic cmd_t mk(bit rd, bit wr, int addr, bit [3:0] be, bit [31:0] data,
                              bit use_c = 0, bit [31:0] ec = 0);
    cmd_t c;
    c = '{default: 0};
    c.rd = rd; c.wr = wr; c.addr = AW'(addr); c.be = be; c.data = data;
    c.use_c = use_c; c.exp_c = ec;
    return c;
  endfunction

  function automatic cmd_t rnd_cmd();
    cmd_t c;
    c = '{default: 0};
    c.addr = ($urandom % 10 == 0) ? AW'(DEPTH + $urandom % 3000) : AW'($urandom % 16);
    c.wr   = 1'($urandom);
    c.rd   = !c.wr || ($urandom % 4 == 0);
    c.be   = 4'($urandom);
    c.data = $urandom;
    c.gap  = ($urandom % 3 == 0) ? int'($urandom % 3) : 0;
    return c;
  endfunction

  task automatic drive();
    s1_chipselect = cv[0];
    s1_read       = cv[0] ? cur[0].rd : 1'($urandom);
    s1_write      = cv[0] ? cur[0].wr : 1'($urandom);
    s1_address    = cv[0] ? cur[0].addr : AW'($urandom);
    s1_byteenable = cv[0] ? cur[0].be : 4'($urandom);
    s1_writedata  = cv[0] ? cur[0].data : $urandom;
    s2_chipselect = cv[1];
    s2_read       = cv[1] ? cur[1].rd : 1'($urandom);
    s2_write      = cv[1] ? cur[1].wr : 1'($urandom);
    s2_address    = cv[1] ? cur[1].addr : AW'($urandom);
    s2_byteenable = cv[1] ? cur[1].be : 4'($urandom);
    s2_writedata  = cv[1] ? cur[1].data : $urandom;
  endtask

  // Driver: one outstanding command per port, held until the model says it was granted.
  initial begin
    drive();
    forever begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (cv[p] && cd[p]) begin cv[p] = 0; cd[p] = 0; end
        if (!cv[p]) begin
          if (p == 0 && q1.size() > 0) begin
            if (gapc[p] < q1[0].gap) gapc[p]++;
            else begin cur[p] = q1.pop_front(); cv[p] = 1; gapc[p] = 0; end
          end
          if (p == 1 && q2.size() > 0) begin
            if (gapc[p] < q2[0].gap) gapc[p]++;
            else begin cur[p] = q2.pop_front(); cv[p] = 1; gapc[p] = 0; end
          end
        end
      end
      drive();
    end
  end

  task automatic apply(input int p);
    cmd_t c;
    exp_t e;
    c = cur[p];
    gcnt[p]++;
    cd[p] = 1;
    if (c.wr) begin
      if (c.addr < DEPTH) begin
        logic [31:0] w;
        w = mref.exists(int'(c.addr)) ? mref[int'(c.addr)] : 32'h0;
        for (int i = 0; i < 4; i++) if (c.be[i]) w[i*8 +: 8] = c.data[i*8 +: 8];
        mref[int'(c.addr)] = w;
      end
    end else begin
      e.data = (c.addr >= DEPTH) ? 32'h0 : mref[int'(c.addr)];
      if (c.use_c) e.data = c.exp_c;
      e.due  = act + RL;
      e.perr = c.flip && (c.addr < DEPTH);
      if (p == 0) sb1.push_back(e); else sb2.push_back(e);
    end
  endtask

  task automatic strobe_chk(input int p, input logic v, input logic [31:0] d, input bit stl);
    exp_t e;
    bit due_now;
    due_now = 0;
    e = '{default: 0};
    if (p == 0 && sb1.size() > 0) begin e = sb1[0]; due_now = (e.due == act) && !stl; end
    if (p == 1 && sb2.size() > 0) begin e = sb2[0]; due_now = (e.due == act) && !stl; end
    chk($sformatf("s%0d_readdatavalid", p + 1), v, due_now);
    if (due_now) begin
      if (p == 0) e = sb1.pop_front(); else e = sb2.pop_front();
      hold[p] = e.data;
      chk($sformatf("s%0d_readdata strobe", p + 1), d, e.data);
`ifdef DESC_MEM_PARITY_EN
      exp_pe = exp_pe | e.perr;
`endif
    end else begin
      chk($sformatf("s%0d_readdata hold", p + 1), d, hold[p]);
    end
  endtask

  // Monitor/model: arbitration, memory and return timing counted in unstalled cycles.
  initial begin
    bit stl, r1, r2, g1, g2, oe;
    act = 0; prio_m = 0; hold[0] = 0; hold[1] = 0;
    forever begin
      @(negedge clk);
      stl = !clken || reset_req || reset;
      if (reset) begin
        sb1.delete(); sb2.delete();
        hold[0] = 0; hold[1] = 0; prio_m = 0;
      end
      if (!stl) act++;
      exp_pe = 0;
      strobe_chk(0, s1_readdatavalid, s1_readdata, stl);
      strobe_chk(1, s2_readdatavalid, s2_readdata, stl);
`ifdef DESC_MEM_PARITY_EN
      chk("parity_err", parity_err, exp_pe);
`endif
      r1 = cv[0] && !cd[0] && (cur[0].rd || cur[0].wr);
      r2 = cv[1] && !cd[1] && (cur[1].rd || cur[1].wr);
      g1 = !stl && r1 && (!r2 || !prio_m);
      g2 = !stl && r2 && (!r1 || prio_m);
      chk("s1_waitrequest", s1_waitrequest, r1 && !g1);
      chk("s2_waitrequest", s2_waitrequest, r2 && !g2);
      oe = (g1 && cur[0].addr >= DEPTH) || (g2 && cur[1].addr >= DEPTH);
      chk("oob_err", oob_err, oe);
      if (!stl && r1 && r2) prio_m = !prio_m;
      if (g1) apply(0);
      if (g2) apply(1);
    end
  end

  function automatic bit busy();
    return q1.size() > 0 || q2.size() > 0 || cv[0] || cv[1] || sb1.size() > 0 || sb2.size() > 0;
  endfunction

  task automatic drain();
    int n = 0;
    while (busy() && n < 3000) begin @(posedge clk); #1; n++; end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL drain timeout: pending=%0d required=0", q1.size() + q2.size() + sb1.size() + sb2.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int p, input int base);
    int n = 0;
    while (gcnt[p] <= base && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL grant timeout: port=%0d grants=%0d required>%0d", p + 1, gcnt[p], base);
    end
  endtask

  initial begin
    int base;
    reset = 1; clken = 1; reset_req = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;

    q1.push_back(mk(0, 1, 'h010, 4'hF, 32'hDEADBEEF));
    q1.push_back(mk(1, 0, 'h010, 4'h0, 0, 1, 32'hDEADBEEF));
    drain();

    q1.push_back(mk(0, 1, 'h020, 4'hF, 32'h11223344));
    drain();
    q2.push_back(mk(0, 1, 'h020, 4'h2, 32'h0000AA00));
    drain();
    q1.push_back(mk(1, 0, 'h020, 4'h0, 0, 1, 32'h1122AA44));
    drain();

    q1.push_back(mk(1, 0, 'h010, 4'h0, 0, 1, 32'hDEADBEEF));
    q2.push_back(mk(1, 0, 'h020, 4'h0, 0, 1, 32'h1122AA44));
    drain();
    q1.push_back(mk(1, 0, 'h020, 4'h0, 0, 1, 32'h1122AA44));
    q2.push_back(mk(1, 0, 'h010, 4'h0, 0, 1, 32'hDEADBEEF));
    drain();

    q2.push_back(mk(0, 1, 'h004, 4'hF, 32'hCAFEF00D));
    q2.push_back(mk(1, 0, DEPTH, 4'h0, 0, 1, 32'h0));
    q2.push_back(mk(1, 1, 5000, 4'hF, 32'h55AA55AA));
    q2.push_back(mk(1, 0, 'h004, 4'h0, 0, 1, 32'hCAFEF00D));
    drain();

    for (int a = 0; a < 16; a++) q2.push_back(mk(0, 1, a, 4'hF, $urandom));
    drain();

    base = gcnt[0];
    for (int a = 0; a < 4; a++) q1.push_back(mk(1, 0, a, 4'h0, 0));
    wait_grant(0, base + 1);
    clken = 0;
    repeat (3) @(posedge clk);
    #1 clken = 1;
    drain();

    q1.push_back(mk(1, 0, 'h010, 4'h0, 0, 1, 32'hDEADBEEF));
    q2.push_back(mk(0, 1, 'h005, 4'hF, 32'h0BADF00D));
    reset_req = 1;
    repeat (4) @(posedge clk);
    #1 reset_req = 0;
    drain();

    for (int k = 0; k < 2 && !prio_m; k++) begin
      q1.push_back(mk(1, 0, 'h010, 4'h0, 0));
      q2.push_back(mk(1, 0, 'h020, 4'h0, 0));
      drain();
    end
    base = gcnt[0];
    q1.push_back(mk(1, 0, 'h004, 4'h0, 0));
    wait_grant(0, base);
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    repeat (3) @(posedge clk);
    #1;
    q1.push_back(mk(1, 0, 'h010, 4'h0, 0, 1, 32'hDEADBEEF));
    q2.push_back(mk(1, 0, 'h020, 4'h0, 0, 1, 32'h1122AA44));
    drain();

`ifdef DESC_MEM_PARITY_EN
    q1.push_back(mk(0, 1, 'h030, 4'hF, 32'h12345678));
    drain();
    dut.mem['h030][DW] = ~dut.mem['h030][DW];
    begin
      cmd_t c;
      c = mk(1, 0, 'h030, 4'h0, 0, 1, 32'h12345678);
      c.flip = 1;
      q1.push_back(c);
    end
    drain();
`endif

    for (int i = 0; i < 200; i++) begin
      q1.push_back(rnd_cmd());
      q2.push_back(rnd_cmd());
    end
    begin
      int n = 0;
      while (busy() && n < 5000) begin
        @(posedge clk); #1;
        clken = ($urandom % 20) != 0;
        reset_req = ($urandom % 30) == 0;
        n++;
      end
    end
    clken = 1; reset_req = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
